// File: rtl/gf_2to4_divider.sv
// Iterative GF((2^2)^2) divider: quotient = x * y^14, computed over six edges on one shared multiplier.
// Includes the combinational composite-field multiplier it time-shares.

module gf_2to4_multiplier #(
    parameter int NB_DATA           = 4,
    parameter bit CREATE_OUTPUT_REG = 1'b0
) (
    input  logic               i_clock,
    input  logic [NB_DATA-1:0] i_data_x,
    input  logic [NB_DATA-1:0] i_data_y,
    output logic [NB_DATA-1:0] o_data_z
);

    // GF(4) with w^2 = w + 1, encoding {w coefficient, 1 coefficient}
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        gf4_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                   (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // Multiply by phi = w
    function automatic logic [1:0] gf4_mul_phi(input logic [1:0] a);
        gf4_mul_phi = {a[1] ^ a[0], a[1]};
    endfunction

    logic [1:0]         hh;
    logic [NB_DATA-1:0] prod;

    always_comb begin
        hh   = gf4_mul(i_data_x[3:2], i_data_y[3:2]);
        prod = {hh ^ gf4_mul(i_data_x[3:2], i_data_y[1:0]) ^ gf4_mul(i_data_x[1:0], i_data_y[3:2]),
                gf4_mul_phi(hh) ^ gf4_mul(i_data_x[1:0], i_data_y[1:0])};
    end

    generate
        if (CREATE_OUTPUT_REG) begin : g_reg
            always_ff @(posedge i_clock) begin
                o_data_z <= prod;
            end
        end else begin : g_comb
            logic unused_clock;
            assign unused_clock = i_clock;
            assign o_data_z     = prod;
        end
    endgenerate

endmodule

module gf_2to4_divider #(
    parameter int NB_DATA = 4,
    parameter int NB_STEP = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_dividend,
    input  logic [NB_DATA-1:0] i_divisor,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_quot,
    output logic               o_div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NB_STEP-1:0] LAST_STEP = NB_STEP'(5);

    state_t             state;
    logic [NB_DATA-1:0] x_reg;
    logic [NB_DATA-1:0] y_reg;
    logic [NB_DATA-1:0] acc;
    logic [NB_STEP-1:0] step;
    logic [NB_DATA-1:0] mul_b;
    logic [NB_DATA-1:0] mul_out;

    // Addition chain y^2, y^3, y^6, y^7, y^14, x*y^14: odd steps use y, the last uses x
    always_comb begin
        mul_b = acc;
        if (step == NB_STEP'(1) || step == NB_STEP'(3)) begin
            mul_b = y_reg;
        end else if (step == LAST_STEP) begin
            mul_b = x_reg;
        end
    end

    gf_2to4_multiplier #(
        .NB_DATA          (NB_DATA),
        .CREATE_OUTPUT_REG(1'b0)
    ) u_mul (
        .i_clock (i_clock),
        .i_data_x(acc),
        .i_data_y(mul_b),
        .o_data_z(mul_out)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            o_ready       <= 1'b1;
            o_valid       <= 1'b0;
            o_quot        <= '0;
            o_div_by_zero <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            acc           <= '0;
            step          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        x_reg   <= i_dividend;
                        y_reg   <= i_divisor;
                        acc     <= i_divisor;
                        step    <= '0;
                        o_ready <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc  <= mul_out;
                    step <= step + NB_STEP'(1);
                    if (step == LAST_STEP) begin
                        o_quot        <= mul_out;
                        o_div_by_zero <= (y_reg == '0);
                        o_valid       <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_2to4_divider.sv
// Self-checking bench for gf_2to4_divider: vector table, exhaustive and random operands,
// backpressure, mid-operation reset and a back-to-back stream.

module tb_gf_2to4_divider;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_dividend;
    logic [3:0] i_divisor;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_quot;
    logic       o_div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clock = ~i_clock;

    gf_2to4_divider #(.NB_DATA(4), .NB_STEP(3)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_quot       (o_quot),
        .o_div_by_zero(o_div_by_zero)
    );

    // GF(4) via logarithms of w (w^2 = w + 1): 1 = w^0, 2 = w^1, 3 = w^2
    function automatic logic [1:0] ref_gf4_mul(input logic [1:0] a, input logic [1:0] b);
        int         lg[4];
        logic [1:0] ex[3];
        lg = '{0, 0, 1, 2};
        ex = '{2'd1, 2'd2, 2'd3};
        if (a == 2'd0 || b == 2'd0) return 2'd0;
        return ex[(lg[a] + lg[b]) % 3];
    endfunction

    // (a1 z + a0)(b1 z + b0) reduced with z^2 = z + phi, phi = w
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = ref_gf4_mul(a[3:2], b[3:2]);
        return {hh ^ ref_gf4_mul(a[3:2], b[1:0]) ^ ref_gf4_mul(a[1:0], b[3:2]),
                ref_gf4_mul(hh, 2'd2) ^ ref_gf4_mul(a[1:0], b[1:0])};
    endfunction

    // Quotient is the unique q with q*y == x; defined as 0 for y == 0
    function automatic logic [3:0] ref_div(input logic [3:0] x, input logic [3:0] y);
        if (y == 4'd0) return 4'd0;
        for (int q = 0; q < 16; q++) begin
            if (ref_mul(4'(q), y) == x) return 4'(q);
        end
        return 4'd0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clock) begin
        if (o_ready === 1'b1 && o_valid === 1'b1) begin
            n_fail++;
            $display("FAIL ready_valid_excl: o_ready=1 and o_valid=1, expected never both (t=%0t)", $time);
        end
    end

    // One operation: accept, count edges to o_valid, optionally stall, then consume
    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input int hold, input bit rnd,
                          output logic [3:0] q, output logic dz);
        int n;
        @(negedge i_clock);
        i_valid = 1'b1; i_dividend = x; i_divisor = y; i_ready = 1'b0;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            @(negedge i_clock);
            n++;
        end
        check("accept_wait", int'(o_ready), 1);
        @(posedge i_clock); #1;
        i_valid = 1'b0; i_dividend = 4'($urandom); i_divisor = 4'($urandom);
        n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            if (rnd) begin
                @(negedge i_clock);
                i_ready = 1'($urandom_range(0, 1));
            end
            @(posedge i_clock); #1;
            n++;
        end
        i_ready = 1'b0;
        check("latency", n, 6);
        q  = o_quot;
        dz = o_div_by_zero;
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clock);
            i_valid = 1'b1; i_dividend = ~x; i_divisor = ~y;
            @(posedge i_clock); #1;
            check("hold_valid", int'(o_valid), 1);
            check("hold_quot", int'(o_quot), int'(q));
            check("hold_dz", int'(o_div_by_zero), int'(dz));
            check("hold_ready", int'(o_ready), 0);
        end
        @(negedge i_clock);
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
        check("consume_valid", int'(o_valid), 0);
        check("consume_ready", int'(o_ready), 1);
        check("consume_quot_kept", int'(o_quot), int'(q));
    endtask

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
        logic       dz;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[9];
        logic [3:0] q, rx, ry;
        logic       dz;
        int         seen;

        // Expected values from field identities and z^2 = z + w, w^2 = w + 1
        vecs = '{
            '{4'h1, 4'h1, 4'h1, 1'b0},
            '{4'h9, 4'h1, 4'h9, 1'b0},
            '{4'h0, 4'hB, 4'h0, 1'b0},
            '{4'hD, 4'hD, 4'h1, 1'b0},
            '{4'h3, 4'h2, 4'h2, 1'b0},
            '{4'h6, 4'h4, 4'h4, 1'b0},
            '{4'h7, 4'h0, 4'h0, 1'b1},
            '{4'h0, 4'h0, 4'h0, 1'b1},
            '{4'hF, 4'hF, 4'h1, 1'b0}
        };

        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_dividend = 4'h0; i_divisor = 4'h0;
        @(posedge i_clock); #1;
        check("rst_ready", int'(o_ready), 1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_quot", int'(o_quot), 0);
        check("rst_dz", int'(o_div_by_zero), 0);
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, 0, 1'b0, q, dz);
            check("vec_quot", int'(q), int'(vecs[i].q));
            check("vec_dz", int'(dz), int'(vecs[i].dz));
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                run_op(4'(x), 4'(y), 0, 1'b0, q, dz);
                check("exh_quot", int'(q), int'(ref_div(4'(x), 4'(y))));
                check("exh_mulback", int'(ref_mul(q, 4'(y))), x);
                check("exh_dz", int'(dz), 0);
            end
        end

        for (int i = 0; i < 100; i++) begin
            rx = 4'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            run_op(rx, ry, 0, 1'b1, q, dz);
            check("rnd_quot", int'(q), int'(ref_div(rx, ry)));
            check("rnd_dz", int'(dz), int'(ry == 4'h0));
        end

        run_op(4'hA, 4'h6, 5, 1'b0, q, dz);
        check("bp_quot", int'(q), int'(ref_div(4'hA, 4'h6)));

        // Reset while the chain is at step 3
        @(negedge i_clock);
        i_valid = 1'b1; i_dividend = 4'h9; i_divisor = 4'h7;
        check("rst_mid_ready_before", int'(o_ready), 1);
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        check("rst_mid_valid", int'(o_valid), 0);
        check("rst_mid_ready", int'(o_ready), 1);
        check("rst_mid_quot", int'(o_quot), 0);
        check("rst_mid_dz", int'(o_div_by_zero), 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clock); #1;
            if (o_valid === 1'b1) seen++;
        end
        check("rst_mid_no_valid", seen, 0);
        run_op(4'h5, 4'h3, 0, 1'b0, q, dz);
        check("rst_after_quot", int'(q), int'(ref_div(4'h5, 4'h3)));
        check("rst_after_mulback", int'(ref_mul(q, 4'h3)), 5);

        // Back-to-back stream with i_valid and i_ready held high
        begin
            logic [3:0] sx[6], sy[6];
            logic [3:0] expq[$];
            int idx = 0, got = 0, last_acc = 0, cyc = 0;
            bit acc;
            for (int i = 0; i < 6; i++) begin
                sx[i] = 4'($urandom);
                sy[i] = 4'($urandom_range(1, 15));
            end
            i_ready = 1'b1;
            while (got < 6 && cyc < 200) begin
                @(negedge i_clock);
                if (idx < 6) begin
                    i_valid = 1'b1; i_dividend = sx[idx]; i_divisor = sy[idx];
                end else begin
                    i_valid = 1'b0;
                end
                acc = i_valid && (o_ready === 1'b1);
                @(posedge i_clock);
                cyc++;
                if (acc) begin
                    expq.push_back(ref_div(sx[idx], sy[idx]));
                    if (idx > 0) check("stream_spacing", cyc - last_acc, 8);
                    last_acc = cyc;
                    idx++;
                end
                #1;
                if (o_valid === 1'b1) begin
                    if (expq.size() > 0) begin
                        check("stream_quot", int'(o_quot), int'(expq.pop_front()));
                    end else begin
                        check("stream_unexpected_valid", 1, 0);
                    end
                    got++;
                end
            end
            check("stream_count", got, 6);
            i_valid = 1'b0; i_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
